parameterized_subtractor_seq: RTL and testbench

- Multi-cycle, parameterized unsigned subtractor: C = A - B. It is the inverse-direction companion to the parameterized adder.
- Processes Chunk_Width bits per clock, least-significant chunk first, with a registered borrow chain.
- Uses a start/busy/done handshake so wide operands do not need a single wide combinational carry path.
- Sits beside the adder in the datapath and is instantiated at 16 and 32 bits like it.

---
 rtl/parameterized_subtractor_seq.sv | 164 ++++++++++++++++
 tb/tb_parameterized_subtractor_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/parameterized_subtractor_seq.sv
// -----------------------------------------------------------------------------
// parameterized_subtractor_seq
//
// Multi-cycle unsigned subtractor: C = A - B (mod 2^Data_Width).
// Works through the operands one Chunk_Width-bit chunk per clock, least
// significant chunk first. A registered borrow links the chunks, so no
// full-width borrow path is built. A start/busy/done handshake controls it.
//
// Parameters
//   Data_Width  : operand and result width in bits
//   Chunk_Width : bits handled per cycle; must divide Data_Width exactly
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : request, sampled only in IDLE or DONE
//   A, B       : minuend / subtrahend, captured on the accepted start edge
//   busy       : high during the N compute cycles
//   done       : one-cycle pulse when C / borrow_out have just been updated
//   C          : registered difference
//   borrow_out : registered final borrow (1 iff A < B)
// -----------------------------------------------------------------------------
module parameterized_subtractor_seq #(
    parameter int Data_Width  = 32,
    parameter int Chunk_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [Data_Width-1:0] A,
    input  logic [Data_Width-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [Data_Width-1:0] C,
    output logic                  borrow_out
);

    localparam int N  = Data_Width / Chunk_Width;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]         K_LAST     = KW'(N - 1);
    localparam logic [Data_Width-1:0] CHUNK_MASK = Data_Width'({Chunk_Width{1'b1}});

    // Reject chunk widths that do not tile the operand exactly.
    if ((Chunk_Width < 1) || ((Data_Width % Chunk_Width) != 0)) begin : g_bad_chunk
        $fatal(1, "Chunk_Width must be positive and divide Data_Width exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [Data_Width-1:0]   a_q, a_d;
    logic [Data_Width-1:0]   b_q, b_d;
    logic [Data_Width-1:0]   res_q, res_d;
    logic                    brw_q, brw_d;
    logic [KW-1:0]           k_q, k_d;
    logic [Data_Width-1:0]   c_q, c_d;
    logic                    bo_q, bo_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [31:0]             shamt_s;
    logic [Chunk_Width-1:0]  a_chunk_s;
    logic [Chunk_Width-1:0]  b_chunk_s;
    logic [Chunk_Width:0]    d_s;
    logic [Data_Width-1:0]   res_merge_s;

    // Current chunk difference and the working result with that chunk merged in.
    always_comb begin
        shamt_s     = 32'(k_q) * 32'(Chunk_Width);
        a_chunk_s   = Chunk_Width'(a_q >> shamt_s);
        b_chunk_s   = Chunk_Width'(b_q >> shamt_s);
        // Top bit of the widened difference is the borrow into the next chunk.
        d_s         = {1'b0, a_chunk_s} - {1'b0, b_chunk_s} - (Chunk_Width + 1)'(brw_q);
        res_merge_s = (res_q & ~(CHUNK_MASK << shamt_s))
                    | (Data_Width'(d_s[Chunk_Width-1:0]) << shamt_s);
    end

    // Next-state and next-output logic; outputs are decoded one cycle ahead
    // so that busy/done come straight from flops.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        k_d     = k_q;
        c_d     = c_q;
        bo_d    = bo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            // DONE accepts a new request exactly like IDLE for back-to-back use.
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = {Data_Width{1'b0}};
                    brw_d   = 1'b0;
                    k_d     = {KW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d = res_merge_s;
                brw_d = d_s[Chunk_Width];
                if (k_q == K_LAST) begin
                    c_d     = res_merge_s;
                    bo_d    = d_s[Chunk_Width];
                    k_d     = {KW{1'b0}};
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {Data_Width{1'b0}};
            b_q     <= {Data_Width{1'b0}};
            res_q   <= {Data_Width{1'b0}};
            brw_q   <= 1'b0;
            k_q     <= {KW{1'b0}};
            c_q     <= {Data_Width{1'b0}};
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            k_q     <= k_d;
            c_q     <= c_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign C          = c_q;
    assign borrow_out = bo_q;

endmodule

// File: tb/tb_parameterized_subtractor_seq.sv
// -----------------------------------------------------------------------------
// tb_parameterized_subtractor_seq
//
// Drives two instances: 32-bit/8-bit chunks (N=4) and 16-bit/16-bit (N=1).
// Expected results come from plain arithmetic on the requested operands;
// expected timing comes from N.
// -----------------------------------------------------------------------------
module tb_parameterized_subtractor_seq;

    logic        clk;
    logic        rst_n;
    logic        start_v [2];
    logic [31:0] a_v     [2];
    logic [31:0] b_v     [2];
    logic        busy_obs[2];
    logic        done_obs[2];
    logic        bo_obs  [2];
    logic [31:0] c_obs   [2];
    logic [15:0] c16_s;

    logic [31:0] exp_c   [2];
    logic        exp_bo  [2];

    int n_checks;
    int n_fails;

    assign c_obs[1] = {16'd0, c16_s};

    parameterized_subtractor_seq #(.Data_Width(32), .Chunk_Width(8)) u_dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[0]),
        .A          (a_v[0]),
        .B          (b_v[0]),
        .busy       (busy_obs[0]),
        .done       (done_obs[0]),
        .C          (c_obs[0]),
        .borrow_out (bo_obs[0])
    );

    parameterized_subtractor_seq #(.Data_Width(16), .Chunk_Width(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[1]),
        .A          (a_v[1][15:0]),
        .B          (b_v[1][15:0]),
        .busy       (busy_obs[1]),
        .done       (done_obs[1]),
        .C          (c16_s),
        .borrow_out (bo_obs[1])
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks = n_checks + 1;
        if (obs !== expv) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] mask_of(input int sel);
        return (sel == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // One full operation; returns positioned in the DONE cycle.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        logic [31:0] am;
        logic [31:0] bm;
        am = a & mask_of(sel);
        bm = b & mask_of(sel);
        a_v[sel]     = a;
        b_v[sel]     = b;
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
        for (int i = 0; i < n_of(sel); i++) begin
            chk("busy_run", 64'(busy_obs[sel]), 64'd1);
            chk("done_run", 64'(done_obs[sel]), 64'd0);
            chk("c_hold_run", 64'(c_obs[sel]), 64'(exp_c[sel]));
            chk("bo_hold_run", 64'(bo_obs[sel]), 64'(exp_bo[sel]));
            if (noise) begin
                start_v[sel] = 1'b1;
                a_v[sel]     = (i == 0) ? 32'hFFFF_FFFF : $urandom;
                b_v[sel]     = (i == 0) ? 32'h0000_0000 : $urandom;
            end
            tick();
        end
        start_v[sel] = 1'b0;
        exp_c[sel]  = (am - bm) & mask_of(sel);
        exp_bo[sel] = (am < bm);
        chk("done_pulse", 64'(done_obs[sel]), 64'd1);
        chk("busy_done", 64'(busy_obs[sel]), 64'd0);
        chk("c_result", 64'(c_obs[sel]), 64'(exp_c[sel]));
        chk("bo_result", 64'(bo_obs[sel]), 64'(exp_bo[sel]));
    endtask

    task automatic idle(input int sel);
        start_v[sel] = 1'b0;
        tick();
        chk("done_idle", 64'(done_obs[sel]), 64'd0);
        chk("busy_idle", 64'(busy_obs[sel]), 64'd0);
        chk("c_hold_idle", 64'(c_obs[sel]), 64'(exp_c[sel]));
        chk("bo_hold_idle", 64'(bo_obs[sel]), 64'(exp_bo[sel]));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b0;
            a_v[s]     = 32'd0;
            b_v[s]     = 32'd0;
            exp_c[s]   = 32'd0;
            exp_bo[s]  = 1'b0;
        end
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", 64'(busy_obs[s]), 64'd0);
            chk("rst_done", 64'(done_obs[s]), 64'd0);
            chk("rst_c", 64'(c_obs[s]), 64'd0);
            chk("rst_bo", 64'(bo_obs[s]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Directed cases on the 4-chunk instance.
        run_op(0, 32'h0000_0002, 32'h0000_0001, 1'b0);
        idle(0);
        run_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        idle(0);
        run_op(0, 32'h0000_0100, 32'h0000_0001, 1'b0);
        idle(0);
        run_op(0, 32'h0000_1234, 32'h0000_0034, 1'b1);
        idle(0);
        idle(0);
        run_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        // Restart straight from DONE.
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op(0, 32'h0000_0000, 32'h0000_0001, 1'b0);
        idle(0);

        // Single-chunk instance.
        run_op(1, 32'h0000_0003, 32'h0000_0003, 1'b0);
        idle(1);
        run_op(1, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op(1, 32'h0000_8000, 32'h0000_0001, 1'b1);
        idle(1);

        // Asynchronous reset during the second RUN cycle of 5 - 3.
        a_v[0]     = 32'd5;
        b_v[0]     = 32'd3;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_obs[0]), 64'd0);
        chk("mid_rst_done", 64'(done_obs[0]), 64'd0);
        chk("mid_rst_c", 64'(c_obs[0]), 64'd0);
        chk("mid_rst_bo", 64'(bo_obs[0]), 64'd0);
        chk("mid_rst_c16", 64'(c_obs[1]), 64'd0);
        for (int s = 0; s < 2; s++) begin
            exp_c[s]  = 32'd0;
            exp_bo[s] = 1'b0;
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(0);
        end

        // Randomized operations on both instances, with random gaps and noise.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(1, 0));
            run_op(sel, $urandom, ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom,
                   bit'($urandom_range(1, 0)));
            if ($urandom_range(1, 0) == 1) begin
                idle(sel);
            end
        end
        idle(0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
